// File: rtl/chunk_store_pkg.sv
// Shared voxel types: block encoding, signed block position and chunk geometry.
// Used by chunk_store and by the traversal unit and other chunk users.
package chunk_store_pkg;

    localparam int unsigned CHUNK_BITS = 4;
    localparam int unsigned COORD_W    = 8;

    typedef enum logic [3:0] {
        BLOCK_AIR   = 4'd0,
        BLOCK_STONE = 4'd1,
        BLOCK_DIRT  = 4'd2,
        BLOCK_GRASS = 4'd3
    } BlockType;

    // x occupies the most significant bits of a packed position, z the least.
    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
    } BlockPos;

    typedef enum logic [1:0] {
        StIdle,
        StReadWait,
        StRespond,
        StClear
    } chunk_state_e;

endpackage

// File: rtl/chunk_store_bram.sv
// Simple dual-port block RAM: port A reads, port B writes, read-first.
// Read data appears LATENCY cycles after the issuing edge.
module chunk_store_bram #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk_in,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem    [2**ADDR_W];
    logic [DATA_W-1:0] pipe_q [LATENCY];

    // Write port.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Array sampled at the issuing edge, so a write on that same edge is not seen.
    always_ff @(posedge clk_in) begin
        if (rd_en) begin
            pipe_q[0] <= mem[rd_addr];
        end
        for (int i = 1; i < LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rd_data = pipe_q[LATENCY-1];

endmodule

// File: rtl/chunk_store.sv
// Voxel chunk responder: single-outstanding reads with fixed latency, bounds check
// returning air outside the chunk, a load write port and a background clear sweep.
module chunk_store
    import chunk_store_pkg::*;
#(
    parameter int unsigned CHUNK_BITS  = chunk_store_pkg::CHUNK_BITS,
    parameter int unsigned COORD_W     = chunk_store_pkg::COORD_W,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [3*COORD_W-1:0]         addr,
    input  logic                         read_enable,
    output logic [$bits(BlockType)-1:0]  out,
    output logic                         valid,
    input  logic [3*COORD_W-1:0]         wr_addr,
    input  logic [$bits(BlockType)-1:0]  wr_data,
    input  logic                         wr_enable,
    input  logic                         clear_start,
    output logic                         busy
);

    localparam int unsigned IDX_W  = 3 * CHUNK_BITS;
    localparam int unsigned CNT_W  = $clog2(MEM_LATENCY + 1);
    localparam int unsigned DATA_W = $bits(BlockType);
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    // A signed coordinate lies in [0, 2^CHUNK_BITS) exactly when every bit above the
    // low CHUNK_BITS is zero; the sign bit is one of them, so negatives never alias.
    function automatic logic in_bounds(input logic [3*COORD_W-1:0] p);
        logic ok;
        ok = 1'b1;
        for (int a = 0; a < 3; a++) begin
            if (p[a*COORD_W+CHUNK_BITS +: (COORD_W-CHUNK_BITS)] != '0) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Index is {z, y, x}; z sits in the low bits of the packed position.
    function automatic logic [IDX_W-1:0] to_index(input logic [3*COORD_W-1:0] p);
        return {p[0 +: CHUNK_BITS], p[COORD_W +: CHUNK_BITS], p[2*COORD_W +: CHUNK_BITS]};
    endfunction

    chunk_state_e       state_q, state_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic [IDX_W-1:0]   clr_q, clr_d;
    logic               inb_q, inb_d;
    logic               pend_q, pend_d;
    BlockType           out_q, out_d;
    logic               valid_q, valid_d;

    logic               rd_en;
    logic [IDX_W-1:0]   rd_idx;
    logic [DATA_W-1:0]  rd_data;
    logic               mem_wr_en;
    logic [IDX_W-1:0]   mem_wr_idx;
    logic [DATA_W-1:0]  mem_wr_data;

    chunk_store_bram #(
        .ADDR_W  (IDX_W),
        .DATA_W  (DATA_W),
        .LATENCY (MEM_LATENCY)
    ) u_bram (
        .clk_in  (clk_in),
        .rd_en   (rd_en),
        .rd_addr (rd_idx),
        .rd_data (rd_data),
        .wr_en   (mem_wr_en),
        .wr_addr (mem_wr_idx),
        .wr_data (mem_wr_data)
    );

    // Next-state logic: request accept, latency count, response, clear sweep.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        clr_d       = clr_q;
        inb_d       = inb_q;
        pend_d      = pend_q;
        out_d       = out_q;
        valid_d     = 1'b0;
        rd_en       = 1'b0;
        rd_idx      = to_index(addr);
        mem_wr_en   = wr_enable && in_bounds(wr_addr);
        mem_wr_idx  = to_index(wr_addr);
        mem_wr_data = wr_data;

        unique case (state_q)
            StIdle: begin
                if (clear_start || pend_q) begin
                    state_d = StClear;
                    pend_d  = 1'b0;
                    clr_d   = '0;
                end else if (read_enable) begin
                    rd_en   = 1'b1;
                    inb_d   = in_bounds(addr);
                    wait_d  = CNT_W'(1);
                    state_d = StReadWait;
                end
            end
            StReadWait: begin
                // A clear requested mid-read starts once the read has completed.
                if (clear_start) begin
                    pend_d = 1'b1;
                end
                if (wait_q == CNT_W'(MEM_LATENCY)) begin
                    state_d = StRespond;
                    wait_d  = '0;
                    valid_d = 1'b1;
                    out_d   = inb_q ? BlockType'(rd_data) : BLOCK_AIR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StRespond: begin
                if (clear_start) begin
                    pend_d = 1'b1;
                end
                state_d = StIdle;
            end
            StClear: begin
                mem_wr_en   = 1'b1;
                mem_wr_idx  = clr_q;
                mem_wr_data = BLOCK_AIR;
                if (clr_q == LAST_IDX) begin
                    state_d = StIdle;
                    clr_d   = '0;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset discards any in-flight read or sweep.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            wait_q  <= '0;
            clr_q   <= '0;
            inb_q   <= 1'b0;
            pend_q  <= 1'b0;
            out_q   <= BLOCK_AIR;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            clr_q   <= clr_d;
            inb_q   <= inb_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = (state_q == StClear);

endmodule
